// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the byte-addressed data RAM between the CPU load/store path (port 0)
//   and the debug/DMA path (port 1). One request is latched at a time and
//   sequenced IDLE -> ACCESS -> RESP. Out-of-range accesses never touch memory.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   mN_req/we/word/addr/wdata request from port N (held until mN_gnt)
//   mN_gnt                   one-cycle accept pulse (ACCESS cycle)
//   mN_rvalid/rdata/err      one-cycle completion (RESP cycle)
//   ram_addr/we/wdata        RAM address, write strobe, write data
//   ram_store_type           1 = word store, 0 = byte store
//   ram_load_type            1 = byte load, 0 = word load
//   ram_rdata                RAM combinational read data
module data_mem_arbiter #(
    parameter int unsigned MEM_BYTES  = 80,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_word,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_word,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_store_type,
    output logic              ram_load_type,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned     CntW     = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveHi = CntW'(STARVE_MAX);
    // Range check is done one bit wider than the address so addr + 3 never wraps.
    localparam logic [ADDR_W:0] LastByte = (ADDR_W + 1)'(MEM_BYTES - 1);
    localparam logic [ADDR_W:0] WordTail = (ADDR_W + 1)'(3);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              word_q, word_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CntW-1:0]   starve_q, starve_d;

    // Arbitration winner and its request fields
    logic              pick1;
    logic              sel_we, sel_word, sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [ADDR_W:0]   sel_end;

    always_comb begin
        pick1     = m1_req & (~m0_req | (starve_q == StarveHi));
        sel_we    = pick1 ? m1_we    : m0_we;
        sel_word  = pick1 ? m1_word  : m0_word;
        sel_addr  = pick1 ? m1_addr  : m0_addr;
        sel_wdata = pick1 ? m1_wdata : m0_wdata;
        // Last byte touched by the access; must still lie inside the RAM.
        sel_end   = {1'b0, sel_addr} + (sel_word ? WordTail : '0);
        sel_err   = sel_end > LastByte;
    end

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        we_d     = we_q;
        word_d   = word_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        starve_d = starve_q;
        unique case (state_q)
            StIdle: begin
                if (!m1_req) begin
                    starve_d = '0;
                end
                if (m0_req || m1_req) begin
                    port_d  = pick1;
                    we_d    = sel_we;
                    word_d  = sel_word;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = sel_err;
                    state_d = StAccess;
                    if (pick1) begin
                        starve_d = '0;
                    end else if (m1_req && (starve_q != StarveHi)) begin
                        // Port 1 lost a contested arbitration
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            StAccess: begin
                rdata_d = (!we_q && !err_q) ? ram_rdata : '0;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            word_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            we_q     <= we_d;
            word_q   <= word_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            starve_q <= starve_d;
        end
    end

    // Outputs decode from registered state only, except ram_we which is also
    // gated by RST so a reset landing in ACCESS cannot write the RAM.
    logic in_access, in_resp;

    always_comb begin
        in_access      = (state_q == StAccess);
        in_resp        = (state_q == StResp);
        m0_gnt         = in_access & ~port_q;
        m1_gnt         = in_access & port_q;
        m0_rvalid      = in_resp & ~port_q;
        m1_rvalid      = in_resp & port_q;
        m0_rdata       = (in_resp & ~port_q) ? rdata_q : '0;
        m1_rdata       = (in_resp & port_q) ? rdata_q : '0;
        m0_err         = in_resp & ~port_q & err_q;
        m1_err         = in_resp & port_q & err_q;
        ram_addr       = in_access ? addr_q : '0;
        ram_we         = in_access & we_q & ~err_q & ~RST;
        ram_store_type = in_access & word_q;
        ram_load_type  = in_access & ~word_q;
        ram_wdata      = in_access ? wdata_q : '0;
    end

endmodule
